// File: rtl/chunked_ripple_adder.sv
// Multi-cycle ripple adder: adds WIDTH-bit operands CHUNK bits per clock behind valid/ready.
// Optional subtract mode is enabled by defining CHUNKED_ADDER_SUB_EN.
module chunked_ripple_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("chunked_ripple_adder: WIDTH must be an exact multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] chunk_ext;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             last_chunk;

`ifdef CHUNKED_ADDER_SUB_EN
  // a - b - cin == a + ~b + ~cin
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~cin : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  // Operands shift down each RUN cycle so the adder always works on bits [CHUNK-1:0].
  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    chunk_ext = '0;
    chunk_ext[CHUNK-1:0] = chunk_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (last_chunk) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    k_d     = k_q;
    if (state_q == StIdle && in_valid) begin
      a_d     = a;
      b_d     = b_eff;
      carry_d = cin_eff;
      sum_d   = '0;
      cout_d  = 1'b0;
      k_d     = '0;
    end else if (state_q == StRun) begin
      a_d     = a_q >> CHUNK;
      b_d     = b_q >> CHUNK;
      carry_d = chunk_sum[CHUNK];
      // sum was cleared at accept, so OR-ing the chunk into place is enough
      sum_d   = sum_q | (chunk_ext << (k_q * CHUNK));
      k_d     = k_q + 1'b1;
      if (last_chunk) cout_d = chunk_sum[CHUNK];
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    sum       = sum_q;
    cout      = cout_q;
  end

endmodule
